// File: rtl/imem_load_controller.sv
`default_nettype none
// ============================================================================
// Module   : imem_load_controller
// Purpose  : Switches the instruction memory between normal core fetch and an
//            in-system program load. A load stalls the core, streams words over
//            a valid/ready handshake to consecutive word addresses, and then
//            pulses a one-cycle core reset so the PC restarts at 0.
// Optional : IMEM_LOAD_CHECKSUM_EN - adds load_csum_i; the XOR of all loaded
//            words must match it, otherwise the load ends in ERROR.
// Ports    : clk, rst_i             - clock, synchronous active-high reset
//            load_start_i/len_i     - load request and word count
//            load_valid_i/data_i    - loader word stream; load_ready_o back
//            fetch_addr_i           - core fetch byte address
//            mem_addr/we/wdata_o    - instruction memory port
//            core_stall_o/reset_o   - core control
//            busy/done/error_o      - status; load_count_o words accepted
// Revision : 1.0 - initial release
// ============================================================================
module imem_load_controller #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 32,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  load_start_i,
  input  logic [LEN_WIDTH-1:0]  load_len_i,
`ifdef IMEM_LOAD_CHECKSUM_EN
  input  logic [DATA_WIDTH-1:0] load_csum_i,
`endif
  input  logic                  load_valid_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  output logic                  load_ready_o,
  input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  core_stall_o,
  output logic                  core_reset_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [LEN_WIDTH-1:0]  load_count_o
);

  // Wide enough to hold DEPTH_WORDS itself, so the pointer never wraps.
  localparam int PTR_W = $clog2(DEPTH_WORDS + 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

  state_t                 state;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [PTR_W-1:0]       ptr;
  logic [LEN_WIDTH-1:0]   load_count;
  logic                   done;

  logic                   len_legal;
  logic                   accept;
  logic                   last_word;
  logic                   csum_ok;
  logic [ADDR_WIDTH-1:0]  ptr_byte_addr;

  assign len_legal = (load_len_i != '0) &&
                     (32'(load_len_i) <= 32'(DEPTH_WORDS));
  assign accept    = (state == ST_LOAD) && load_valid_i;
  assign last_word = ((load_count + LEN_WIDTH'(1)) == len_q);
  assign ptr_byte_addr = ADDR_WIDTH'(ptr) << 2;

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]  csum_q;
  logic [DATA_WIDTH-1:0]  csum_acc;
  // Include the word being accepted so the final compare needs no extra cycle.
  assign csum_ok = ((csum_acc ^ load_data_i) == csum_q);
`else
  assign csum_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state      <= ST_RUN;
      len_q      <= '0;
      ptr        <= '0;
      load_count <= '0;
      done       <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum_q     <= '0;
      csum_acc   <= '0;
`endif
    end else begin
      case (state)
        ST_RUN, ST_ERROR: begin
          if (load_start_i) begin
            len_q      <= load_len_i;
            ptr        <= '0;
            load_count <= '0;
            done       <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum_q     <= load_csum_i;
            csum_acc   <= '0;
`endif
            state      <= len_legal ? ST_LOAD : ST_ERROR;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            ptr        <= ptr + PTR_W'(1);
            load_count <= load_count + LEN_WIDTH'(1);
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum_acc   <= csum_acc ^ load_data_i;
`endif
            if (last_word) begin
              state <= csum_ok ? ST_RELEASE : ST_ERROR;
            end
          end
        end
        ST_RELEASE: begin
          done  <= 1'b1;
          state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Outputs decode directly from the registered state; only the memory write
  // path passes the loader handshake through combinationally (zero latency).
  assign load_ready_o = (state == ST_LOAD);
  assign mem_we_o     = accept;
  assign mem_wdata_o  = accept ? load_data_i : '0;
  assign mem_addr_o   = (state == ST_LOAD) ? ptr_byte_addr : fetch_addr_i;
  assign core_stall_o = (state != ST_RUN);
  assign core_reset_o = (state == ST_RELEASE);
  assign busy_o       = (state == ST_LOAD) || (state == ST_RELEASE);
  assign error_o      = (state == ST_ERROR);
  assign done_o       = done;
  assign load_count_o = load_count;

endmodule
`default_nettype wire
